pipe_hazard_controller: RTL and testbench

- Stall/interlock sequencer for the 5-stage pipelined CPU; sits in ID beside the forwarding controller.
- Detects the load-use hazard that forwarding cannot cover, because the EXE-stage load result is not yet available.
- Tracks the multi-cycle multiply/divide unit (MDU) busy window and stalls HI/LO readers and back-to-back MDU ops.
- Drives PC/IF-ID write enable, the ID→EXE bubble, the MDU start pulse, and a stall performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/mdu_busy_timer.sv | 56 +++++
 rtl/pipe_hazard_controller.sv | 61 ++++++
 tb/tb_pipe_hazard_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_busy_timer.sv
// rtl/mdu_busy_timer.sv - tracks the window in which HI/LO results are still pending
module mdu_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy
);

    mdu_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // State and down-counter registers; reset may hit mid-BUSY and drops straight to IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: load latency on issue, count down, leave BUSY when the last cycle is reached
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(MDU_LATENCY);
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/pipe_hazard_controller.sv
// rtl/pipe_hazard_controller.sv - load-use and MDU interlock with stall performance counter
module pipe_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int PERF_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_mdu_op,
    input  logic             ID_hilo_read,
    input  logic             EXE_wreg,
    input  logic             EXE_m2reg,
    input  logic [REG_W-1:0] EXE_write_reg_number,
    output logic             wpcir,
    output logic             bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    logic load_use;
    logic mdu_hz;
    logic stall;

    // A load in EXE cannot forward its data yet; r0 is hardwired and never a real dependency
    always_comb begin
        load_use = EXE_wreg & EXE_m2reg & (EXE_write_reg_number != REG_ZERO) &
                   ((ID_uses_rs & (EXE_write_reg_number == ID_rs)) |
                    (ID_uses_rt & (EXE_write_reg_number == ID_rt)));
        mdu_hz   = mdu_busy & (ID_hilo_read | ID_mdu_op);
        stall    = load_use | mdu_hz;
    end

    assign wpcir     = ~stall;
    assign bubble    = stall;
    assign mdu_start = ID_mdu_op & ~stall;

    mdu_busy_timer #(
        .MDU_LATENCY(MDU_LATENCY)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .start(mdu_start),
        .busy (mdu_busy)
    );

    // Saturating count of held cycles so long runs never wrap back to a small value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// tb/tb_pipe_hazard_controller.sv - directed self-checking bench for pipe_hazard_controller
module tb_pipe_hazard_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EXE_write_reg_number;
    logic        ID_uses_rs, ID_uses_rt, ID_mdu_op, ID_hilo_read;
    logic        EXE_wreg, EXE_m2reg;
    logic        wpcir, bubble, mdu_start, mdu_busy;
    logic [15:0] stall_cycles;
    logic        wpcir1, bubble1, mdu_start1, mdu_busy1;
    logic [15:0] stall_cycles1;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;

    always #5 clock = ~clock;

    pipe_hazard_controller #(.MDU_LATENCY(4), .PERF_W(16)) dut (
        .clock(clock), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_mdu_op(ID_mdu_op), .ID_hilo_read(ID_hilo_read),
        .EXE_wreg(EXE_wreg), .EXE_m2reg(EXE_m2reg),
        .EXE_write_reg_number(EXE_write_reg_number),
        .wpcir(wpcir), .bubble(bubble), .mdu_start(mdu_start),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    pipe_hazard_controller #(.MDU_LATENCY(1), .PERF_W(16)) dut1 (
        .clock(clock), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_mdu_op(ID_mdu_op), .ID_hilo_read(ID_hilo_read),
        .EXE_wreg(EXE_wreg), .EXE_m2reg(EXE_m2reg),
        .EXE_write_reg_number(EXE_write_reg_number),
        .wpcir(wpcir1), .bubble(bubble1), .mdu_start(mdu_start1),
        .mdu_busy(mdu_busy1), .stall_cycles(stall_cycles1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        ID_mdu_op = 1'b0; ID_hilo_read = 1'b0;
        EXE_wreg = 1'b0; EXE_m2reg = 1'b0; EXE_write_reg_number = 5'd0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();

        // reset state
        settle();
        chk("rst_busy", mdu_busy, 1'b0);
        chk("rst_sc", stall_cycles, 16'd0);
        chk("rst_wpcir", wpcir, 1'b1);
        chk("rst_bubble", bubble, 1'b0);
        ID_mdu_op = 1'b1;
        settle();
        chk("rst_start_follow", mdu_start, 1'b1);
        ID_mdu_op = 1'b0;
        settle();
        chk("rst_start_zero", mdu_start, 1'b0);
        reset = 1'b0;
        tick();

        // latency-1 unit: busy for exactly one cycle
        ID_mdu_op = 1'b1;
        settle();
        chk("l1_start", mdu_start1, 1'b1);
        tick();
        ID_mdu_op = 1'b0;
        settle();
        chk("l1_busy_t1", mdu_busy1, 1'b1);
        tick();
        chk("l1_busy_t2", mdu_busy1, 1'b0);
        tick(); tick(); tick(); tick();
        chk("main_idle_after", mdu_busy, 1'b0);
        exp_sc = 0;
        chk("sc_zero_pre", stall_cycles, exp_sc);

        // load-use on rs
        EXE_wreg = 1'b1; EXE_m2reg = 1'b1; EXE_write_reg_number = 5'd8;
        ID_rs = 5'd8; ID_uses_rs = 1'b1;
        settle();
        chk("lu_rs_wpcir", wpcir, 1'b0);
        chk("lu_rs_bubble", bubble, 1'b1);
        tick();
        exp_sc++;
        EXE_m2reg = 1'b0;
        settle();
        chk("alu_fwd_wpcir", wpcir, 1'b1);
        chk("lu_sc1", stall_cycles, exp_sc);
        tick();
        chk("alu_fwd_sc", stall_cycles, exp_sc);

        // register 0 never stalls
        EXE_m2reg = 1'b1; EXE_write_reg_number = 5'd0; ID_rs = 5'd0;
        settle();
        chk("r0_wpcir", wpcir, 1'b1);

        // rt match without use does not stall; with use it does
        EXE_write_reg_number = 5'd8; ID_rs = 5'd3; ID_uses_rs = 1'b0;
        ID_rt = 5'd8; ID_uses_rt = 1'b0;
        settle();
        chk("rt_nouse_wpcir", wpcir, 1'b1);
        ID_uses_rt = 1'b1;
        settle();
        chk("rt_use_bubble", bubble, 1'b1);
        clear_inputs();
        settle();
        chk("cleared_wpcir", wpcir, 1'b1);
        tick();

        // MDU issue then mfhi held in ID
        ID_mdu_op = 1'b1;
        settle();
        chk("mdu_start_T", mdu_start, 1'b1);
        chk("mdu_busy_T", mdu_busy, 1'b0);
        tick();
        ID_mdu_op = 1'b0; ID_hilo_read = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk($sformatf("mfhi_busy_T%0d", i), mdu_busy, 1'b1);
            chk($sformatf("mfhi_wpcir_T%0d", i), wpcir, 1'b0);
            tick();
            exp_sc++;
        end
        chk("mfhi_busy_T5", mdu_busy, 1'b0);
        chk("mfhi_wpcir_T5", wpcir, 1'b1);
        chk("mfhi_sc", stall_cycles, exp_sc);
        ID_hilo_read = 1'b0;
        tick();

        // load-use together with an MDU op suppresses issue until unstalled
        EXE_wreg = 1'b1; EXE_m2reg = 1'b1; EXE_write_reg_number = 5'd9;
        ID_rt = 5'd9; ID_uses_rt = 1'b1; ID_mdu_op = 1'b1;
        settle();
        chk("lu_mdu_start", mdu_start, 1'b0);
        chk("lu_mdu_bubble", bubble, 1'b1);
        tick();
        exp_sc++;
        chk("lu_mdu_notbusy", mdu_busy, 1'b0);
        EXE_m2reg = 1'b0;
        settle();
        chk("lu_mdu_issue", mdu_start, 1'b1);
        tick();
        clear_inputs();
        settle();
        chk("lu_mdu_busy", mdu_busy, 1'b1);
        tick(); tick(); tick(); tick();
        chk("lu_mdu_done", mdu_busy, 1'b0);
        chk("lu_mdu_sc", stall_cycles, exp_sc);

        // back-to-back MDU ops
        ID_mdu_op = 1'b1;
        settle();
        chk("b2b_first_start", mdu_start, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("b2b_start_T%0d", i), mdu_start, 1'b0);
            chk($sformatf("b2b_wpcir_T%0d", i), wpcir, 1'b0);
            tick();
            exp_sc++;
        end
        chk("b2b_busy_T5", mdu_busy, 1'b0);
        chk("b2b_start_T5", mdu_start, 1'b1);
        tick();
        ID_mdu_op = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            settle();
            chk($sformatf("b2b_busy_T%0d", i), mdu_busy, 1'b1);
            tick();
        end
        chk("b2b_busy_T10", mdu_busy, 1'b0);
        chk("b2b_sc", stall_cycles, exp_sc);

        // reset in the middle of a busy window
        ID_mdu_op = 1'b1;
        tick();
        ID_mdu_op = 1'b0; ID_hilo_read = 1'b1;
        tick();
        chk("midrst_busy_pre", mdu_busy, 1'b1);
        chk("midrst_wpcir_pre", wpcir, 1'b0);
        reset = 1'b1;
        settle();
        chk("midrst_busy", mdu_busy, 1'b0);
        chk("midrst_sc", stall_cycles, 16'd0);
        chk("midrst_wpcir", wpcir, 1'b1);
        tick();
        reset = 1'b0;
        clear_inputs();
        tick();

        // saturation of the stall counter
        EXE_wreg = 1'b1; EXE_m2reg = 1'b1; EXE_write_reg_number = 5'd5;
        ID_rs = 5'd5; ID_uses_rs = 1'b1;
        repeat (65534) tick();
        chk("sat_near", stall_cycles, 16'hFFFE);
        repeat (4) tick();
        chk("sat_hold", stall_cycles, 16'hFFFF);
        chk("sat_wpcir", wpcir, 1'b0);
        clear_inputs();
        tick();
        chk("sat_after", stall_cycles, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
